sram_like_responder: RTL and testbench

Slave-side (responder) model of the sram-like instruction/data memory interface that the fetch and memory stages drive. It accepts requests through the req/addr_ok address handshake and returns data_ok/rdata in order after a fixed latency, backed by an internal word-addressed memory. The block serves as the inst/data memory endpoint in simulation and FPGA builds. A test hook exercises addr_ok back-pressure.

---
 rtl/sram_like_responder.sv | 94 +++++++++
 tb/tb_sram_like_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// Responder for the sram-like memory interface: address handshake on req/addr_ok,
// in-order data_ok/rdata a fixed RESP_LAT cycles after each accept.
module sram_like_responder #(
   parameter int MEM_AW          = 12,
   parameter int RESP_LAT        = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        stall_in,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int         PTR_W   = $clog2(MAX_OUTSTANDING);
   localparam int         CNT_W   = PTR_W + 1;
   localparam logic [3:0] LAT_M1  = 4'(RESP_LAT - 1);
   localparam logic [3:0] LAT_SAT = 4'(RESP_LAT);

   logic [31:0]                mem    [2**MEM_AW];
   logic [31:0]                q_data [MAX_OUTSTANDING];
   logic [3:0]                 q_age  [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] q_valid;
   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           rd_ptr;
   logic [CNT_W-1:0]           count;
   logic [MEM_AW-1:0]          index;
   logic                       accept;
   logic                       retire;
   logic                       unused_ok;

   // Byte offset and bits above the memory index do not select anything.
   assign index     = addr[MEM_AW+1:2];
   assign unused_ok = ^{size, addr[31:MEM_AW+2], addr[1:0]};

   // count is the registered occupancy; a retire this cycle does not free a slot early.
   assign addr_ok = resetn && req && !stall_in && (count < CNT_W'(MAX_OUTSTANDING));
   assign accept  = req && addr_ok;
   assign retire  = resetn && q_valid[rd_ptr] && (q_age[rd_ptr] == LAT_M1);
   assign data_ok = retire;
   assign rdata   = retire ? q_data[rd_ptr] : 32'h0;

   // NOTE: memory has no reset branch; contents survive resetn and come from preload.
   always_ff @(posedge clk) begin
      if (accept && wr) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Entry payload needs no reset: q_valid decides whether it is ever looked at.
   always_ff @(posedge clk) begin
      if (accept) q_data[wr_ptr] <= wr ? 32'h0 : mem[index];
   end

   // NOTE: all state here uses non-blocking assignments so same-edge reads see old values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         q_valid <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) q_age[i] <= 4'd0;
      end else begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (q_valid[i] && (q_age[i] != LAT_SAT)) q_age[i] <= q_age[i] + 4'd1;
         end
         if (retire) begin
            q_valid[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + PTR_W'(1);
         end
         // Accept last: a fresh entry always starts at age 0.
         if (accept) begin
            q_valid[wr_ptr] <= 1'b1;
            q_age[wr_ptr]   <= 4'd0;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         case ({accept, retire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed and random requests compared each cycle
// against a due-time response queue and a byte-level reference memory.
module tb_sram_like_responder;

   localparam int MEM_AW = 12;
   localparam int LAT    = 8;
   localparam int MAXO   = 4;
   localparam logic [31:0] BASE = 32'h1C00_0000;

   logic        clk;
   logic        resetn;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall_in;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   sram_like_responder #(
      .MEM_AW(MEM_AW),
      .RESP_LAT(LAT),
      .MAX_OUTSTANDING(MAXO)
   ) u_dut (
      .clk(clk),
      .resetn(resetn),
      .req(req),
      .wr(wr),
      .size(size),
      .wstrb(wstrb),
      .addr(addr),
      .wdata(wdata),
      .stall_in(stall_in),
      .addr_ok(addr_ok),
      .data_ok(data_ok),
      .rdata(rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] data;
   } resp_t;

   resp_t       exp_q[$];
   logic [31:0] ref_mem [int];
   int          cyc      = 0;
   int          n_total  = 0;
   int          n_pass   = 0;
   bit          last_acc = 1'b0;
   bit          rand_stall = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
   endtask

   // One clock cycle: compare at the falling edge, advance the model, move past the rising edge.
   task automatic cycle();
      bit          e_aok;
      bit          e_dok;
      logic [31:0] e_rd;
      int          idx;
      @(negedge clk);
      e_aok = resetn && req && !stall_in && (exp_q.size() < MAXO);
      e_dok = resetn && (exp_q.size() > 0) && (exp_q[0].due == cyc);
      e_rd  = e_dok ? exp_q[0].data : 32'h0;
      check("addr_ok", {31'b0, addr_ok}, {31'b0, e_aok});
      check("data_ok", {31'b0, data_ok}, {31'b0, e_dok});
      check("rdata", rdata, e_rd);
      last_acc = e_aok;
      if (!resetn) begin
         exp_q.delete();
      end else begin
         if (e_dok) void'(exp_q.pop_front());
         if (e_aok) begin
            idx = int'((addr >> 2) & ((32'd1 << MEM_AW) - 1));
            if (wr) begin
               exp_q.push_back('{due: cyc + LAT, data: 32'h0});
               for (int b = 0; b < 4; b++) begin
                  if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
               end
            end else begin
               exp_q.push_back('{due: cyc + LAT, data: ref_mem[idx]});
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      req      = 1'b0;
      stall_in = 1'b0;
      repeat (n) cycle();
   endtask

   // Hold a request until the model says it was accepted, bounded.
   task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      int n = 0;
      req   = 1'b1;
      wr    = w;
      addr  = a;
      wdata = d;
      wstrb = s;
      size  = 2'(($urandom_range(0, 2)));
      do begin
         stall_in = rand_stall && ($urandom_range(0, 3) == 0);
         cycle();
         n++;
      end while (!last_acc && n < 64);
      check("accept_bound", {31'b0, last_acc}, 32'd1);
      req      = 1'b0;
      stall_in = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr(input int idx);
      return ($urandom & 32'hFFFF_C000) | (32'(idx) << 2) | ($urandom & 32'h3);
   endfunction

   initial begin
      resetn   = 1'b0;
      req      = 1'b0;
      wr       = 1'b0;
      size     = 2'd2;
      wstrb    = 4'h0;
      addr     = 32'h0;
      wdata    = 32'h0;
      stall_in = 1'b0;
      // Reset state, with a request pending that must not be accepted.
      cycle();
      req = 1'b1;
      cycle();
      req    = 1'b0;
      resetn = 1'b1;

      // Preload the 16 words used below; first accept is in the first cycle out of reset.
      for (int i = 0; i < 16; i++) issue(1'b1, BASE + 32'(i * 4), $urandom, 4'hF);
      idle(LAT + 2);

      // Full write then read of the same word.
      issue(1'b1, 32'h1C00_0010, 32'hDEAD_BEEF, 4'hF);
      issue(1'b0, 32'h1C00_0010, 32'h0, 4'h0);
      idle(LAT + 2);

      // Partial write of lane 1 into a known word.
      issue(1'b1, 32'h1C00_0014, 32'h1122_3344, 4'hF);
      issue(1'b1, 32'h1C00_0014, 32'h0000_AB00, 4'b0010);
      issue(1'b0, 32'h1C00_0014, 32'h0, 4'h0);
      idle(LAT + 2);

      // Five back-to-back reads against a four-deep queue.
      for (int i = 0; i < 5; i++) issue(1'b0, BASE + 32'(i * 4), 32'h0, 4'h0);
      idle(LAT + 2);

      // Stall hook holds addr_ok low, then the request is taken.
      req      = 1'b1;
      wr       = 1'b0;
      addr     = BASE + 32'h8;
      stall_in = 1'b1;
      repeat (3) cycle();
      issue(1'b0, BASE + 32'h8, 32'h0, 4'h0);
      idle(LAT + 2);

      // Reset with responses outstanding, then a read right after reset.
      for (int i = 0; i < 3; i++) issue(1'b0, BASE + 32'(i * 4), 32'h0, 4'h0);
      resetn = 1'b0;
      repeat (2) cycle();
      resetn = 1'b1;
      issue(1'b0, 32'h1C00_0010, 32'h0, 4'h0);
      idle(LAT + 4);

      // Alternating random writes/reads, misaligned addresses, random stalls.
      rand_stall = 1'b1;
      for (int i = 0; i < 64; i++) begin
         issue(i[0] == 1'b0, rand_addr($urandom_range(0, 15)), $urandom,
               4'($urandom_range(0, 15)));
      end
      rand_stall = 1'b0;
      idle(LAT + 4);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
